spi_fl_master_cfg: RTL

Parametrised SPI flash master, mode 0, single I/O. It is the successor to the fixed-format flash master in the SPI flash controller path. Each transaction is built from programmable phases: command, optional address, dummy cycles, and an optional write or read data phase of 0..DATA_W/8 bytes. The SCLK rate is set by a divider. The controller side uses a validflag/tready accept handshake and receives a one-cycle completion pulse.

---
 rtl/spi_fl_master_cfg.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_fl_master_cfg.sv
`timescale 1ns/1ps
// Mode-0 single-I/O SPI flash master with programmable command, address,
// dummy and data phases; valid/ready request side, one-cycle done pulse.
module spi_fl_master_cfg #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 24,
    parameter int SCLK_HALF = 1,
    parameter int DUMMY_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ss,
    output logic                      sclk,
    output logic                      mosi,
    input  logic                      miso,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W-1:0]         data_out,
    input  logic [ADDR_W-1:0]         address,
    input  logic [7:0]                command,
    input  logic                      addr_en,
    input  logic [DUMMY_W-1:0]        dummy,
    input  logic [$clog2(DATA_W/8):0] nbytes,
    input  logic                      rd_nwr,
    input  logic                      validflag,
    output logic                      validflag_out,
    output logic                      tready
);
    localparam int NB_W = $clog2(DATA_W/8) + 1;
    localparam int MAXB = DATA_W / 8;
    localparam int CW   = (DUMMY_W > 7) ? DUMMY_W : 7;
    localparam int DVW  = $clog2(2 * SCLK_HALF);

    localparam logic [DVW-1:0] CELL_LAST = DVW'(2 * SCLK_HALF - 1);
    localparam logic [DVW-1:0] HALF_LAST = DVW'(SCLK_HALF - 1);
    localparam logic [DVW-1:0] HALF      = DVW'(SCLK_HALF);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END
    } state_t;

    state_t state, state_d;

    logic [DVW-1:0]     div;
    logic [CW-1:0]      bit_cnt, load_cnt;
    logic [7:0]         cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  dat_q, rx_q;
    logic               ae_q, rd_q, done;
    logic [DUMMY_W-1:0] dummy_q;
    logic [NB_W-1:0]    nb_q, nb_c;
    logic               cell_end, last, busy;
    state_t             after_cmd, after_addr, after_dummy;

    assign nb_c     = (nbytes > NB_W'(MAXB)) ? NB_W'(MAXB) : nbytes;
    assign cell_end = (div == CELL_LAST);
    assign last     = (bit_cnt == '0);
    assign busy     = (state == ST_CMD) || (state == ST_ADDR) ||
                      (state == ST_DUMMY) || (state == ST_DATA);

    // Empty phases are skipped by chaining the "what comes next" choices.
    assign after_dummy = (nb_q != '0) ? ST_DATA : ST_END;
    assign after_addr  = (dummy_q != '0) ? ST_DUMMY : after_dummy;
    assign after_cmd   = ae_q ? ST_ADDR : after_addr;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:  if (validflag) state_d = ST_CMD;
            ST_CMD:   if (cell_end && last) state_d = after_cmd;
            ST_ADDR:  if (cell_end && last) state_d = after_addr;
            ST_DUMMY: if (cell_end && last) state_d = after_dummy;
            ST_DATA:  if (cell_end && last) state_d = ST_END;
            ST_END:   if (div == HALF_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_cnt = '0;
        unique case (state_d)
            ST_ADDR:  load_cnt = CW'(ADDR_W - 1);
            ST_DUMMY: load_cnt = CW'(dummy_q) - CW'(1);
            ST_DATA:  load_cnt = CW'(8 * int'(nb_q) - 1);
            default:  load_cnt = '0;
        endcase
    end

    always_comb begin
        mosi = 1'b0;
        unique case (state)
            ST_CMD:  mosi = cmd_q[7];
            ST_ADDR: mosi = addr_q[ADDR_W-1];
            ST_DATA: mosi = ~rd_q & dat_q[DATA_W-1];
            default: mosi = 1'b0;
        endcase
    end

    assign ss            = (state == ST_IDLE);
    assign tready        = (state == ST_IDLE);
    assign sclk          = busy && (div >= HALF);
    assign validflag_out = done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            dat_q    <= '0;
            rx_q     <= '0;
            ae_q     <= 1'b0;
            rd_q     <= 1'b0;
            dummy_q  <= '0;
            nb_q     <= '0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_d;
            done  <= 1'b0;
            if (state == ST_IDLE) begin
                if (validflag) begin
                    cmd_q   <= command;
                    addr_q  <= address;
                    // Write payload is left-justified so it leaves MSB first.
                    dat_q   <= data_in << (DATA_W - 8 * int'(nb_c));
                    ae_q    <= addr_en;
                    rd_q    <= rd_nwr;
                    dummy_q <= dummy;
                    nb_q    <= nb_c;
                    rx_q    <= '0;
                    div     <= '0;
                    bit_cnt <= CW'(7);
                end
            end else if (state == ST_END) begin
                div <= div + 1'b1;
                if (div == HALF_LAST) begin
                    div  <= '0;
                    done <= 1'b1;
                    if (rd_q && nb_q != '0) data_out <= rx_q;
                end
            end else begin
                div <= cell_end ? '0 : div + 1'b1;
                if (state == ST_DATA && div == HALF_LAST)
                    rx_q <= {rx_q[DATA_W-2:0], miso};
                if (cell_end) begin
                    if (last) begin
                        bit_cnt <= load_cnt;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        unique case (state)
                            ST_CMD:  cmd_q  <= cmd_q << 1;
                            ST_ADDR: addr_q <= addr_q << 1;
                            ST_DATA: dat_q  <= dat_q << 1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule
